// File: rtl/button_bounce_gen.sv
// button_bounce_gen: turns a clean level request into a bouncing button waveform, then holds the settled level
module button_bounce_gen #(
  parameter int          CLK_FREQ  = 95_000,
  parameter int          N_BOUNCES = 4,
  parameter int          SEG_W     = 4,
  parameter int          SETTLE_US = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic        RST_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic level_req,
  input  logic en_bounce,
  output logic button_out,
  output logic busy,
  output logic done
);
  localparam int PRE_N = CLK_FREQ / 1000;
  localparam int PW = $clog2(PRE_N + 1);
  localparam int BW = $clog2(2 * N_BOUNCES + 2);
  localparam int SW = $clog2(SETTLE_US + 1);
  localparam int CW = SEG_W + 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRE_N - 1);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;
  localparam logic [1:0] IDLE = 2'd0, BOUNCE = 2'd1, SETTLE = 2'd2;
  logic [1:0] state_q, state_d;
  logic button_out_q, button_out_d, busy_q, busy_d, done_q, done_d, target_q, target_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [CW-1:0] seg_q, seg_d, seglen;
  logic [BW-1:0] bnc_q, bnc_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [PW-1:0] pre_q, pre_d;
  logic tick;
  assign button_out = button_out_q;
  assign busy = busy_q;
  assign done = done_q;
  // sequencer: µs prescaler, LFSR segment widths and the IDLE/BOUNCE/SETTLE walk
  always_comb begin
    tick = busy_q && (pre_q == PRE_MAX);
    lfsr_nx = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    seglen = CW'(lfsr_q[SEG_W-1:0]) + CW'(1);
    state_d = state_q;
    button_out_d = button_out_q;
    busy_d = busy_q;
    done_d = 1'b0;
    target_d = target_q;
    lfsr_d = lfsr_q;
    seg_d = seg_q;
    bnc_d = bnc_q;
    settle_d = settle_q;
    pre_d = (!busy_q || tick) ? '0 : pre_q + PW'(1);
    case (state_q)
      IDLE: if (level_req != button_out_q) begin
        button_out_d = level_req;
        if (en_bounce) begin
          target_d = level_req;
          seg_d = seglen;
          bnc_d = BW'(2 * N_BOUNCES);
          lfsr_d = lfsr_nx;
          state_d = BOUNCE;
          busy_d = 1'b1;
          pre_d = '0;
        end else done_d = 1'b1;
      end
      BOUNCE: if (tick) begin
        seg_d = seg_q - CW'(1);
        if (seg_q == CW'(1)) begin
          if (bnc_q == '0) begin
            state_d = SETTLE;
            settle_d = SW'(SETTLE_US);
            pre_d = '0;
          end else begin
            button_out_d = ~button_out_q;
            bnc_d = bnc_q - BW'(1);
            seg_d = seglen;
            lfsr_d = lfsr_nx;
          end
        end
      end
      SETTLE: begin
        button_out_d = target_q;
        if (tick) begin
          settle_d = settle_q - SW'(1);
          if (settle_q == SW'(1)) begin
            state_d = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      button_out_q <= RST_LEVEL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      target_q <= RST_LEVEL;
      lfsr_q <= SEED;
      seg_q <= '0;
      bnc_q <= '0;
      settle_q <= '0;
      pre_q <= '0;
    end else begin
      state_q <= state_d;
      button_out_q <= button_out_d;
      busy_q <= busy_d;
      done_q <= done_d;
      target_q <= target_d;
      lfsr_q <= lfsr_d;
      seg_q <= seg_d;
      bnc_q <= bnc_d;
      settle_q <= settle_d;
      pre_q <= pre_d;
    end
  end
endmodule

// File: tb/tb_button_bounce_gen.sv
// tb_button_bounce_gen: cycle-exact check of button_bounce_gen against a waveform model built from segment lengths
module tb_button_bounce_gen;
  localparam int CF = 1000, NB = 2, SEGW = 2, ST = 5, US = CF / 1000;
  localparam logic [15:0] SEED = 16'h0001;
  logic clk = 1'b0, rst = 1'b0, level_req = 1'b0, en_bounce = 1'b0;
  logic button_out, busy, done;
  int checks = 0, errors = 0;
  logic [15:0] m_lfsr = SEED;
  logic m_out = 1'b0;

  button_bounce_gen #(.CLK_FREQ(CF), .N_BOUNCES(NB), .SEG_W(SEGW), .SETTLE_US(ST),
                      .LFSR_SEED(SEED), .RST_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .level_req(level_req), .en_bounce(en_bounce),
    .button_out(button_out), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // Galois LFSR over x^16+x^14+x^13+x^11+1, stepped once per generated segment
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Expects the request to be presented before the next edge; returns at #1 after the done edge.
  // mode 1 scrambles inputs while busy, mode 2 leaves level_req opposite to tgt for a back-to-back start.
  task automatic run_seq(input logic tgt, input int mode);
    int lens[$];
    logic [2:0] exp;
    logic lvl;
    for (int i = 0; i < 2 * NB + 1; i++) begin
      lens.push_back(1 + int'(m_lfsr & 16'((1 << SEGW) - 1)));
      m_lfsr = lfsr_next(m_lfsr);
    end
    @(posedge clk); #1;
    for (int i = 0; i < lens.size(); i++) begin
      lvl = (i % 2 == 0) ? tgt : ~tgt;
      for (int c = 0; c < lens[i] * US; c++) begin
        exp = {lvl, 1'b1, 1'b0};
        checks++;
        if ({button_out, busy, done} !== exp) begin
          errors++;
          $display("FAIL seg%0d cyc%0d t=%0t: got out/busy/done=%b expected %b", i, c, $time, {button_out, busy, done}, exp);
        end
        if (mode == 1) begin
          level_req = ($urandom_range(0, 1) == 1);
          en_bounce = ($urandom_range(0, 1) == 1);
        end
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < ST * US; k++) begin
      exp = {tgt, 1'b1, 1'b0};
      checks++;
      if ({button_out, busy, done} !== exp) begin
        errors++;
        $display("FAIL settle cyc%0d t=%0t: got out/busy/done=%b expected %b", k, $time, {button_out, busy, done}, exp);
      end
      if (mode == 1) begin
        level_req = (k == ST * US - 1) ? tgt : ($urandom_range(0, 1) == 1);
        en_bounce = (k == ST * US - 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
      end
      if (mode == 2 && k == ST * US - 1) level_req = ~tgt;
      @(posedge clk); #1;
    end
    checks++;
    if ({button_out, busy, done} !== {tgt, 2'b01}) begin
      errors++;
      $display("FAIL done t=%0t: got out/busy/done=%b expected %b", $time, {button_out, busy, done}, {tgt, 2'b01});
    end
    m_out = tgt;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({button_out, busy, done} !== {m_out, 2'b00}) begin
        errors++;
        $display("FAIL idle t=%0t: got out/busy/done=%b expected %b", $time, {button_out, busy, done}, {m_out, 2'b00});
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({button_out, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset: got out/busy/done=%b expected 000", {button_out, busy, done});
      end
    end
    rst = 1'b1;
    m_lfsr = SEED;
    m_out = 1'b0;
  endtask

  task automatic test_bounce;
    @(negedge clk);
    level_req = 1'b1;
    en_bounce = 1'b1;
    run_seq(1'b1, 0);
    idle_check(2);
  endtask

  task automatic test_clean(input logic lvl);
    @(negedge clk);
    en_bounce = 1'b0;
    level_req = lvl;
    @(posedge clk); #1;
    checks++;
    if ({button_out, busy, done} !== {lvl, 2'b01}) begin
      errors++;
      $display("FAIL clean: got out/busy/done=%b expected %b", {button_out, busy, done}, {lvl, 2'b01});
    end
    m_out = lvl;
    idle_check(2);
  endtask

  task automatic test_ignored;
    @(negedge clk);
    level_req = ~m_out;
    en_bounce = 1'b1;
    run_seq(~m_out, 1);
    idle_check(4);
  endtask

  task automatic test_reset_mid;
    test_clean(1'b0);
    @(negedge clk);
    en_bounce = 1'b1;
    level_req = 1'b1;
    @(posedge clk);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({button_out, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got out/busy/done=%b expected 000", {button_out, busy, done});
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({button_out, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold: got out/busy/done=%b expected 000", {button_out, busy, done});
      end
    end
    @(negedge clk);
    rst = 1'b1;
    m_lfsr = SEED;
    m_out = 1'b0;
    run_seq(1'b1, 0);
    idle_check(2);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    en_bounce = 1'b1;
    level_req = ~m_out;
    run_seq(~m_out, 2);
    run_seq(~m_out, 0);
    idle_check(2);
  endtask

  task automatic test_random;
    logic lr, en;
    repeat (8) begin
      idle_check($urandom_range(0, 3));
      lr = ($urandom_range(0, 1) == 1);
      en = ($urandom_range(0, 1) == 1);
      if (lr != m_out && en) begin
        @(negedge clk);
        en_bounce = 1'b1;
        level_req = lr;
        run_seq(lr, 0);
        idle_check(1);
      end else if (lr != m_out) test_clean(lr);
      else begin
        @(negedge clk);
        en_bounce = en;
        level_req = lr;
        idle_check(2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_clean(1'b0);
    test_ignored;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_bounce_gen.md
Name: button_bounce_gen

Overview:
- Synthesizable button-bounce emulator: the transmitting end of the button_deb interface.
- Converts a clean requested level into a bouncing waveform of pseudo-random segment widths, then holds the settled level.
- Used in on-FPGA self-test, with button_out driving button_deb.button_in, and in benches as a reusable stimulus source.

Parameters:
- CLK_FREQ, 95_000: clock frequency in kHz; must be a multiple of 1000 and at least 1000.
- N_BOUNCES, 4: bounce pairs per transition; 0 is legal.
- SEG_W, 4: segment width field; each segment lasts 1..2^SEG_W µs.
- SETTLE_US, 20: stable hold time after the final toggle, in µs; must be at least 1.
- LFSR_SEED, 16'hACE1: LFSR reset value; 0 is replaced by 1.
- RST_LEVEL, 0: button_out value at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- level_req  in  1  requested clean button level
- en_bounce  in  1  1 = emulate bounce; 0 = clean transition
- button_out  out  1  emulated raw button signal
- busy  out  1  high while a transition sequence is in progress
- done  out  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset (rst=0, async): state=IDLE, button_out=RST_LEVEL, busy=0, done=0, lfsr=LFSR_SEED (or 1 if the seed is 0), all counters 0.
- µs tick: prescaler counts 0..CLK_FREQ/1000-1 and is active only when busy. tick=1 on the terminal count. The prescaler clears on entry to BOUNCE or SETTLE.
- LFSR: 16-bit Galois, taps 16'hB400. It advances only when a segment length is loaded.
- seglen = 1 + lfsr[SEG_W-1:0] µs.
- IDLE
  - done=0 except as noted in the SETTLE and clean-transition rules.
  - If level_req != button_out and en_bounce=1: on the next edge button_out<=level_req (first toggle), target<=level_req, seg_cnt<=seglen, bnc_cnt<=2*N_BOUNCES, lfsr advances, state<=BOUNCE, busy<=1.
  - If level_req != button_out and en_bounce=0: on the next edge button_out<=level_req and done<=1. busy stays 0 and state stays IDLE.
  - If level_req == button_out: no action.
- BOUNCE: seg_cnt decrements on each tick. On a tick with seg_cnt==1:
  - if bnc_cnt==0: state<=SETTLE, settle_cnt<=SETTLE_US;
  - else: button_out<=~button_out, bnc_cnt<=bnc_cnt-1, seg_cnt<=seglen, lfsr advances.
  - The 2*N_BOUNCES extra toggles are even in number, so the waveform ends at target.
- SETTLE
  - button_out holds target; settle_cnt decrements on each tick.
  - On the tick with settle_cnt==1: state<=IDLE, busy<=0, done<=1 for one cycle.
- Input changes while busy:
  - level_req and en_bounce are ignored.
  - The next sequence can start no earlier than the cycle after done.
  - If level_req still differs from button_out on that cycle, a new sequence starts.
- Latency:
  - First toggle appears 1 cycle after the request is sampled.
  - Total sequence time = sum of (2*N_BOUNCES+1) segment lengths + SETTLE_US, in µs.
- N_BOUNCES=0: single toggle, one segment, then settle.
- Reset asserted mid-sequence: immediate return to reset values. No done pulse; the LFSR restarts from the seed.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset, then bounce sequence. Params CLK_FREQ=1000 (1 tick/cycle), N_BOUNCES=2, SEG_W=2, SETTLE_US=5, seed 16'h0001. Hold rst=0 for 3 cycles, release, then level_req 0->1 with en_bounce=1.
   -> While rst=0: button_out=0, busy=0.
   -> After release: exactly 5 edges on button_out (0->1->0->1->0->1). Each segment length matches the reference-model LFSR sequence. Final level 1. done pulses exactly once, 5 cycles after the last segment ends.
2. Clean transition. en_bounce=0, level_req 1->0.
   -> button_out=0 one cycle later, done high for one cycle, busy never asserted.
3. Request ignored while busy. Toggle level_req 1->0->1 during BOUNCE.
   -> Sequence unaffected. After done, no new sequence because level_req equals button_out.
4. Reset mid-sequence. Assert rst during BOUNCE.
   -> button_out=RST_LEVEL and busy=0 immediately (async), no done pulse. After release, a repeat of scenario 1 reproduces identical segment lengths.
5. Loopback into button_deb. Defaults CLK_FREQ=95_000, debounce 20 ms, SETTLE_US=25_000, with level_req 0->1->0.
   -> button_valid rises once and falls once, with no glitches during bounce.
6. Back-to-back requests. level_req changed so it differs from button_out in the cycle done fires.
   -> New sequence starts on the next edge (busy=1 one cycle after done). The LFSR continues from its prior state without reseeding.
